// File: rtl/multdiv_sequencer_if.sv
// Operation request / result bundle for multdiv_sequencer.
interface multdiv_sequencer_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/multdiv_sequencer.sv
// 32-iteration sequential multiply / restoring divide with divide-by-zero exception.
// Define MULTDIV_SIGNED_EN for two's-complement operands (sign fix-up applied at FINISH).
//
// state  | meaning
// IDLE   | waiting for start; hi/lo hold last result
// RUN    | one shift-add / shift-subtract iteration per edge, 32 edges
// FINISH | write hi/lo (sign-corrected), pulse done
// DZ     | divide by zero: pulse done + div_zero, results untouched
module multdiv_sequencer (
    input  logic               clk,
    input  logic               reset,
    multdiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH, DZ} state_t;

    state_t      state, state_nxt;
    logic        accept, load_res;
    logic [5:0]  cnt;
    logic        op_r;
    logic [31:0] opnd;
    logic [63:0] acc, acc_step, res;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum, rem_sh, diff;
    logic        done_r, dz_r;
    logic [31:0] hi_r, lo_r;

`ifdef MULTDIV_SIGNED_EN
    logic neg_a_r, neg_b_r;

    assign mag_a = bus.a[31] ? 32'd0 - bus.a : bus.a;
    assign mag_b = bus.b[31] ? 32'd0 - bus.b : bus.b;

    // Quotient sign follows the operand signs, remainder follows the dividend.
    always_comb begin
        res = acc;
        if (op_r) begin
            res[31:0]  = (neg_a_r ^ neg_b_r) ? 32'd0 - acc[31:0] : acc[31:0];
            res[63:32] = neg_a_r ? 32'd0 - acc[63:32] : acc[63:32];
        end else if (neg_a_r ^ neg_b_r) begin
            res = 64'd0 - acc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
        end else if (accept) begin
            neg_a_r <= bus.a[31];
            neg_b_r <= bus.b[31];
        end
    end
`else
    assign mag_a = bus.a;
    assign mag_b = bus.b;
    assign res   = acc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_res  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op && (bus.b == 32'd0)) begin
                        state_nxt = DZ;
                    end else begin
                        state_nxt = RUN;
                        accept    = 1'b1;
                    end
                end
            end
            RUN:    if (cnt == 6'd31) state_nxt = FINISH;
            FINISH: begin
                state_nxt = IDLE;
                load_res  = 1'b1;
            end
            DZ:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc is {partial product hi, multiplier} for MULT and {remainder, quotient} for DIV.
    always_comb begin
        sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        rem_sh = acc[63:31];
        diff   = rem_sh - {1'b0, opnd};
        if (op_r) acc_step = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                      : {diff[31:0], acc[30:0], 1'b1};
        else      acc_step = {sum, acc[31:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 6'd0;
            op_r   <= 1'b0;
            opnd   <= 32'd0;
            acc    <= 64'd0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else begin
            done_r <= (state == FINISH) || (state == DZ);
            dz_r   <= (state == DZ);
            if (accept) begin
                op_r <= bus.op;
                cnt  <= 6'd0;
                acc  <= bus.op ? {32'd0, mag_a} : {32'd0, mag_b};
                opnd <= bus.op ? mag_b : mag_a;
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + 6'd1;
            end
            if (load_res) begin
                hi_r <= res[63:32];
                lo_r <= res[31:0];
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomised + directed bench for multdiv_sequencer against an arithmetic reference model.
module tb_multdiv_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    multdiv_sequencer_if bus ();

    multdiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}.
    function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
`ifdef MULTDIV_SIGNED_EN
        longint pa, pb;
        int sa, sb, q, m;
        if (!op) begin
            pa = longint'(signed'(a));
            pb = longint'(signed'(b));
            r  = 64'(pa * pb);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {32'd0, 32'h8000_0000};
        end else begin
            sa = signed'(a);
            sb = signed'(b);
            q  = sa / sb;
            m  = sa % sb;
            r  = {32'(m), 32'(q)};
        end
`else
        if (!op) r = {32'd0, a} * {32'd0, b};
        else     r = {a % b, a / b};
`endif
        return r;
    endfunction

    // Cycle model: an accepted op completes 33 edges later (1 edge for divide-by-zero).
    int          left = 0;
    logic        pend_dz = 1'b0;
    logic [63:0] pend = 64'd0;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_dz = 1'b0;
    logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            left = 0; exp_busy = 0; exp_done = 0; exp_dz = 0; exp_hi = 0; exp_lo = 0;
        end else begin
            exp_done = 0;
            exp_dz   = 0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    exp_done = 1;
                    exp_dz   = pend_dz;
                    if (!pend_dz) {exp_hi, exp_lo} = pend;
                end
            end else if (bus.start) begin
                pend_dz = bus.op && (bus.b == 32'd0);
                left    = pend_dz ? 1 : 33;
                if (!pend_dz) pend = ref_result(bus.op, bus.a, bus.b);
            end
            exp_busy = (left > 0);
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("done", 32'(bus.done), 32'(exp_done));
        check("div_zero", 32'(bus.div_zero), 32'(exp_dz));
        check("hi", bus.hi, exp_hi);
        check("lo", bus.lo, exp_lo);
    end

    // Issue one op at a negedge; operands are scrambled after acceptance.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b, input int poke,
                         output int lat, output logic busy1);
        int k;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        busy1 = bus.busy;
        bus.a = $urandom; bus.b = $urandom; bus.op = 1'($urandom);
        for (k = 1; k <= 40; k++) begin
            if (bus.done) break;
            if (k == poke) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        lat = k;
        if (k > 40) check("done_timeout", 32'(k), 32'd34);
    endtask

    initial begin
        int lat;
        logic b1;
        logic [31:0] ra, rb;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(1'b0, 32'd7, 32'd6, 0, lat, b1);
        check("mul76_lat", 32'(lat), 32'd34);
        check("mul76_busy_e0", 32'(b1), 32'd1);
        check("mul76_hi", bus.hi, 32'h0);
        check("mul76_lo", bus.lo, 32'h2A);

        do_op(1'b1, 32'd100, 32'd7, 0, lat, b1);
        check("div100_lo", bus.lo, 32'hE);
        check("div100_hi", bus.hi, 32'h2);
        check("div100_dz", 32'(bus.div_zero), 32'd0);

        do_op(1'b1, 32'd5, 32'd0, 0, lat, b1);
        check("dz_lat", 32'(lat), 32'd2);
        check("dz_flag", 32'(bus.div_zero), 32'd1);
        check("dz_hi", bus.hi, 32'h2);
        check("dz_lo", bus.lo, 32'hE);

        do_op(1'b0, 32'hFFFF_FFFD, 32'd5, 0, lat, b1);
`ifdef MULTDIV_SIGNED_EN
        check("mulneg_hi", bus.hi, 32'hFFFF_FFFF);
`else
        check("mulneg_hi", bus.hi, 32'h0000_0004);
`endif
        check("mulneg_lo", bus.lo, 32'hFFFF_FFF1);

        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, b1);
`ifdef MULTDIV_SIGNED_EN
        check("divm7_lo", bus.lo, 32'hFFFF_FFFD);
        check("divm7_hi", bus.hi, 32'hFFFF_FFFF);
`else
        check("divm7_lo", bus.lo, 32'h7FFF_FFFC);
        check("divm7_hi", bus.hi, 32'h1);
`endif

        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, b1);
        check("ovf_dz", 32'(bus.div_zero), 32'd0);
`ifdef MULTDIV_SIGNED_EN
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'h0);
`else
        check("ovf_lo", bus.lo, 32'h0);
        check("ovf_hi", bus.hi, 32'h8000_0000);
`endif

        do_op(1'b0, 32'h1234, 32'h10, 10, lat, b1);
        check("poke_lat", 32'(lat), 32'd34);
        check("poke_lo", bus.lo, 32'h12340);
        check("poke_hi", bus.hi, 32'h0);

        // Reset in the middle of an operation.
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd11; bus.b = 32'd13;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);

        do_op(1'b0, 32'd3, 32'd3, 0, lat, b1);
        check("mul33_lo", bus.lo, 32'd9);

        // Back-to-back random ops, each started in the done cycle of the previous one.
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                default: rb = 32'($urandom);
            endcase
            do_op(1'($urandom), ra, rb, (n % 5 == 0) ? int'($urandom_range(2, 30)) : 0, lat, b1);
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-004 op  input  1  operation select: 0 = MULT, 1 = DIV.
REQ-005 a  input  32  multiplicand or dividend; sampled on the accepting edge.
REQ-006 b  input  32  multiplier or divisor; sampled on the accepting edge.
REQ-007 busy  output  1  high while an accepted operation is in progress.
REQ-008 done  output  1  one-cycle registered pulse; the result or exception is valid.
REQ-009 div_zero  output  1  one-cycle pulse, coincident with done, for a DIV whose divisor is 0.
REQ-010 hi  output  32  MULT: upper product word. DIV: remainder.
REQ-011 lo  output  32  MULT: lower product word. DIV: quotient.

Function
REQ-012 States SHALL be IDLE, RUN, FINISH and DZ.
- IDLE -> RUN: start=1 with no divide-by-zero.
- IDLE -> DZ: start=1, op=1, b=0.
- RUN -> FINISH: after the 32nd iteration.
- FINISH -> IDLE and DZ -> IDLE: unconditional.
REQ-013 Accepting edge E0 SHALL latch op, a and b, and clear the 6-bit iteration counter; busy SHALL rise after E0.
REQ-014 RUN SHALL perform one iteration per edge on E1..E32: shift-add for MULT, restoring shift-subtract for DIV; the counter SHALL increment to 32, then the state SHALL go to FINISH.
REQ-015 At edge E33 (FINISH) the block SHALL:
- write hi/lo;
- pulse done high for exactly one cycle;
- drop busy;
- return to IDLE.
REQ-016 MULT SHALL produce {hi,lo} = full 64-bit product of the operands.
REQ-017 DIV SHALL produce lo = quotient truncated toward zero and hi = remainder, with the remainder taking the sign of the dividend.
REQ-018 Divide-by-zero SHALL be handled as follows:
- no iterations run;
- at E1, done=1 and div_zero=1 for one cycle, busy returns low;
- hi and lo keep their previous values.
REQ-019 hi and lo SHALL hold their last written values until the next FINISH; they SHALL NOT change during RUN.
REQ-020 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-021 start asserted in the cycle where done=1 (state IDLE) SHALL be accepted on the next edge.
REQ-022 When operand inputs change after E0, results SHALL be unaffected.
REQ-023 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 and no exception.

Reset
REQ-024 Asserting reset SHALL immediately force:
- the state to IDLE;
- the counter to 0;
- busy, done and div_zero to 0;
- hi and lo to 0.
REQ-025 Reset asserted during RUN or FINISH SHALL abort the operation with no done pulse; the first start after deassertion SHALL be accepted normally.

Configuration
REQ-026 Macro MULTDIV_SIGNED_EN: when defined, operands SHALL be two's-complement signed. Magnitudes are computed with the unsigned core, and result signs are corrected at FINISH within the same E33 edge, adding no latency.
REQ-027 When MULTDIV_SIGNED_EN is undefined, operands and results SHALL be unsigned 32-bit, and sign-correction logic SHALL be absent.

Verification
REQ-028 MULT 7 x 6 -> hi=0x00000000, lo=0x0000002A; done high in the cycle after E33; busy high E0..E33.
REQ-029 DIV 100 / 7 -> lo=0x0000000E, hi=0x00000002; div_zero stays 0.
REQ-030 After the REQ-029 result, DIV 5 / 0 -> done=1 and div_zero=1 one cycle after E0; hi=0x00000002 and lo=0x0000000E unchanged.
REQ-031 MULT a=0xFFFFFFFD, b=5:
- with the macro: hi=0xFFFFFFFF, lo=0xFFFFFFF1;
- without the macro: hi=0x00000004, lo=0xFFFFFFF1.
REQ-032 With the macro, DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also cover 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 start pulsed at E10 during a MULT -> ignored, original result unchanged. Reset pulsed at E15 of a new operation -> busy=0, hi=lo=0 with no clock edge, no done pulse. A next start of 3 x 3 -> lo=9.
